spart_key_decoder: RTL and testbench

//   Parametrised keyboard decoder between the SPART receiver and the CPU. Detects rda rising

---
 rtl/spart_key_decoder.sv | 148 ++++++++++++++
 tb/tb_spart_key_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spart_key_decoder.sv
// Keyboard decoder: SPART rda edges matched case-insensitively against a key table, held-key timeout, event FIFO.
// Define SPART_KEY_RELEASE_EVT_EN to also queue release events when a held key times out.
module spart_key_decoder #(
  parameter int NUM_KEYS = 5,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES = {8'h77, 8'h61, 8'h73, 8'h64, 8'h6A},
  parameter int HOLD_CYCLES = 5000000,
  parameter int FIFO_DEPTH = 8,
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rda,
  input  logic [7:0]          databus,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                evt_valid,
  output logic [IDX_W:0]      evt_data,
  input  logic                evt_ready,
  output logic                evt_ovf,
  input  logic                ovf_clr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic                rda_q;
  logic                strobe;
  logic [7:0]          cmp_code;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [NUM_KEYS-1:0] reload;
  logic                press_req;
  logic                push_req;
  logic [IDX_W:0]      push_data;
  logic                rel_drop;
  logic [CNT_W-1:0]    cnt [NUM_KEYS];

  logic [IDX_W:0]      mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr, wr_next, rd_next;
  logic                empty, full, pop, do_push, ovf_set;
  logic [IDX_W:0]      head_next;

  assign strobe = rda & ~rda_q;

  // Uppercase letters fold to lowercase; descending scan lets the lowest matching index win.
  always_comb begin
    cmp_code = (databus >= 8'h41 && databus <= 8'h5A) ? (databus | 8'h20) : databus;
    hit      = 1'b0;
    hit_idx  = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (KEY_CODES[8*k +: 8] == cmp_code) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    reload = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      reload[k] = strobe && hit && (hit_idx == IDX_W'(k));
    end
  end

  // A repeated character on an already-held key only refreshes its timer.
  assign press_req = (|reload) && !(|(reload & key_state));

`ifdef SPART_KEY_RELEASE_EVT_EN
  logic [NUM_KEYS-1:0] expire;
  logic                rel_valid;
  logic                rel_multi;
  logic [IDX_W-1:0]    rel_idx;

  always_comb begin
    expire  = '0;
    rel_idx = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      expire[k] = (cnt[k] == CNT_W'(1)) && !reload[k];
      if (expire[k]) rel_idx = IDX_W'(k);
    end
    rel_valid = |expire;
    rel_multi = (expire & (expire - NUM_KEYS'(1))) != '0;
    push_req  = press_req | rel_valid;
    push_data = press_req ? {1'b0, hit_idx} : {1'b1, rel_idx};
    rel_drop  = rel_valid && (press_req || rel_multi);
  end
`else
  always_comb begin
    push_req  = press_req;
    push_data = {1'b0, hit_idx};
    rel_drop  = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rda_q     <= 1'b0;
      key_state <= '0;
      for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
    end else begin
      rda_q <= rda;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (reload[k]) begin
          cnt[k]       <= CNT_W'(HOLD_CYCLES);
          key_state[k] <= 1'b1;
        end else if (cnt[k] != '0) begin
          cnt[k] <= cnt[k] - CNT_W'(1);
          if (cnt[k] == CNT_W'(1)) key_state[k] <= 1'b0;
        end
      end
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = !empty && evt_ready;
  assign do_push   = push_req && (!full || pop);
  assign rd_next   = rd_ptr + (AW+1)'(pop);
  assign wr_next   = wr_ptr + (AW+1)'(do_push);
  assign ovf_set   = (push_req && full && !pop) || rel_drop;
  assign evt_valid = !empty;

  // evt_data is registered, so the next head is predicted here, including a write landing on it.
  always_comb begin
    if (wr_next == rd_next)                head_next = '0;
    else if (do_push && wr_ptr == rd_next) head_next = push_data;
    else                                   head_next = mem[rd_next[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      evt_data <= '0;
      evt_ovf  <= 1'b0;
    end else begin
      wr_ptr   <= wr_next;
      rd_ptr   <= rd_next;
      evt_data <= head_next;
      if (ovf_set)      evt_ovf <= 1'b1;
      else if (ovf_clr) evt_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_key_decoder.sv
// Randomized and directed bench for spart_key_decoder against a time-stamp/queue reference model.
module tb_spart_key_decoder;

  localparam int N = 5;
  localparam int H = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rda = 1'b0;
  logic [7:0]   databus = 8'h00;
  logic [N-1:0] key_state;
  logic         evt_valid;
  logic [3:0]   evt_data;
  logic         evt_ready = 1'b0;
  logic         evt_ovf;
  logic         ovf_clr = 1'b0;

  int assert_count = 0;
  int fail_count = 0;

  spart_key_decoder #(
    .NUM_KEYS(N), .KEY_CODES({8'h77, 8'h61, 8'h73, 8'h64, 8'h6A}),
    .HOLD_CYCLES(H), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .rda(rda), .databus(databus),
    .key_state(key_state), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_ready(evt_ready), .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Model: a key is held in cycle c when its last strobe s satisfies s < c <= s+H.
  byte unsigned codes [N] = '{8'h6A, 8'h64, 8'h73, 8'h61, 8'h77};
  int  last_strobe [N];
  int  evt_q [$];
  bit  ovf_m;
  bit  prev_rda;
  int  cyc = 0;

  function automatic bit held(int k, int c);
    return (c > last_strobe[k]) && (c <= last_strobe[k] + H);
  endfunction

  function automatic byte unsigned fold(byte unsigned b);
    return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
  endfunction

  task automatic modelStep();
    bit strobe, hit, drop, pop;
    int idx;
    int pushes [$];
    if (rst) begin
      foreach (last_strobe[k]) last_strobe[k] = -1000;
      evt_q.delete();
      ovf_m = 0;
      prev_rda = 0;
      return;
    end
    strobe = rda && !prev_rda;
    prev_rda = rda;
    hit = 0;
    idx = 0;
    drop = 0;
    if (strobe) begin
      for (int k = 0; k < N; k++) begin
        if (!hit && codes[k] == fold(databus)) begin
          hit = 1;
          idx = k;
        end
      end
    end
    if (hit && !held(idx, cyc)) pushes.push_back(idx);
`ifdef SPART_KEY_RELEASE_EVT_EN
    for (int k = 0; k < N; k++) begin
      if (held(k, cyc) && last_strobe[k] + H == cyc && !(hit && idx == k)) begin
        if (pushes.size() == 0) pushes.push_back(8 + k);
        else drop = 1;
      end
    end
`endif
    if (hit) last_strobe[idx] = cyc;
    pop = (evt_q.size() > 0) && evt_ready;
    if (pop) void'(evt_q.pop_front());
    if (pushes.size() > 0) begin
      if (evt_q.size() < D) evt_q.push_back(pushes[0]);
      else drop = 1;
    end
    if (drop) ovf_m = 1;
    else if (ovf_clr) ovf_m = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic checkModel();
    logic [N-1:0] exp_ks;
    for (int k = 0; k < N; k++) exp_ks[k] = held(k, cyc);
    checkOutput("key_state", 32'(key_state), 32'(exp_ks));
    checkOutput("evt_valid", 32'(evt_valid), 32'(evt_q.size() > 0));
    checkOutput("evt_data", 32'(evt_data), (evt_q.size() > 0) ? 32'(evt_q[0]) : 32'd0);
    checkOutput("evt_ovf", 32'(evt_ovf), 32'(ovf_m));
  endtask

  task automatic applyStimulus(input bit r, input bit rda_v, input logic [7:0] db,
                               input bit ready, input bit clr);
    rst = r;
    rda = rda_v;
    databus = db;
    evt_ready = ready;
    ovf_clr = clr;
    modelStep();
    @(posedge clk);
    cyc++;
    #1;
    checkModel();
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, ready, 0);
  endtask

  task automatic press(input logic [7:0] code, input bit ready);
    applyStimulus(0, 1, code, ready, 0);
    applyStimulus(0, 0, code, ready, 0);
  endtask

  initial begin
    applyStimulus(1, 0, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);

    applyStimulus(0, 1, 8'h57, 0, 0);
    checkOutput("t1_key_state", 32'(key_state), 32'b10000);
    checkOutput("t1_evt_data", 32'(evt_data), 32'b0100);
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("t1_pop_valid", 32'(evt_valid), 32'd0);
    idle(12, 1);

    press(8'h61, 1);
    idle(3, 1);
    press(8'h61, 1);
    idle(12, 1);

    press(8'h7A, 1);
    press(8'h31, 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 8'h6A, 1, 0);
    idle(12, 1);

    applyStimulus(0, 1, 8'h64, 1, 0);
    idle(7, 1);
    applyStimulus(0, 1, 8'h44, 1, 0);
    checkOutput("t5_reload_held", 32'(key_state[1]), 32'd1);
    idle(12, 1);

    press(8'h77, 0);
    press(8'h61, 0);
    press(8'h73, 0);
    press(8'h64, 0);
    press(8'h6A, 0);
    idle(10, 0);
    press(8'h77, 0);
    checkOutput("t3_ovf_set", 32'(evt_ovf), 32'd1);
    applyStimulus(0, 0, 8'h00, 0, 1);
    idle(6, 1);

    press(8'h73, 0);
    press(8'h64, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("t6_reset_ks", 32'(key_state), 32'd0);
    applyStimulus(0, 1, 8'h6A, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      logic [7:0] db;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0)      db = codes[$urandom_range(0, N - 1)];
      else if (sel == 1) db = codes[$urandom_range(0, N - 1)] & 8'hDF;
      else               db = 8'($urandom_range(0, 255));
      applyStimulus(($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 2) == 0) ? ~rda : rda, db,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
